// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor: token encoding, debounce states, queue depth.
package coin_pkg;
    localparam int FIFO_DEPTH = 4;

    typedef logic tok_t;
    localparam tok_t TOK_HALF = 1'b0;
    localparam tok_t TOK_ONE  = 1'b1;

    typedef enum logic [1:0] {LOW, QUAL_HIGH, HIGH, QUAL_LOW} db_state_t;
endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor inputs, control, and coin pulses of the coin acceptor.
// COIN_TOTAL_EN adds the credit_total signal.
interface coin_acceptor_if;
    logic       coin_half_raw;
    logic       coin_one_raw;
    logic       accept_en;
    logic       hold;
    logic       half;
    logic       one;
    logic       reject;
    logic [2:0] fifo_level;
`ifdef COIN_TOTAL_EN
    logic [7:0] credit_total;

    modport master (output coin_half_raw, coin_one_raw, accept_en, hold,
                    input  half, one, reject, fifo_level, credit_total);
    modport slave  (input  coin_half_raw, coin_one_raw, accept_en, hold,
                    output half, one, reject, fifo_level, credit_total);
`else
    modport master (output coin_half_raw, coin_one_raw, accept_en, hold,
                    input  half, one, reject, fifo_level);
    modport slave  (input  coin_half_raw, coin_one_raw, accept_en, hold,
                    output half, one, reject, fifo_level);
`endif
endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce FSM, single-cycle event on a
// qualified rising level.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic coin_ev
);
    // The cycle that enters a QUAL state already counts as the first stable sample.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync;
    logic            s;
    db_state_t       state;
    logic [DB_W-1:0] cnt;

    assign s = sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[0], raw};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= LOW;
            cnt     <= '0;
            coin_ev <= 1'b0;
        end else begin
            coin_ev <= 1'b0;
            case (state)
                LOW: if (s) begin
                    state <= QUAL_HIGH;
                    cnt   <= DB_W'(1);
                end
                QUAL_HIGH: begin
                    if (!s) state <= LOW;
                    else if (cnt == CNT_LAST) begin
                        state   <= HIGH;
                        coin_ev <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                end
                HIGH: if (!s) begin
                    state <= QUAL_LOW;
                    cnt   <= DB_W'(1);
                end
                QUAL_LOW: begin
                    if (s) state <= HIGH;
                    else if (cnt == CNT_LAST) state <= LOW;
                    else cnt <= cnt + 1'b1;
                end
                default: state <= LOW;
            endcase
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: two debounced sensors feed a 4-token FIFO popped into
// half/one pulses. Optional COIN_TOTAL_EN adds a saturating credit_total.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 8
) (
    input  logic            clk,
    input  logic            reset,
    coin_acceptor_if.slave  bus
);
    localparam logic [2:0] FULL = 3'(FIFO_DEPTH);

    logic                  ev_half, ev_one;
    logic                  pend_one;
    logic [FIFO_DEPTH-1:0] fifo;
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            level;
    logic                  half_q, one_q, reject_q;
    logic                  push_vld, pop, accept;
    tok_t                  push_tok;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_half (
        .clk(clk), .reset(reset), .raw(bus.coin_half_raw), .coin_ev(ev_half));
    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_one (
        .clk(clk), .reset(reset), .raw(bus.coin_one_raw), .coin_ev(ev_one));

    // A deferred one-coin wins the push slot; otherwise half beats one.
    always_comb begin
        push_vld = pend_one | ev_half | ev_one;
        push_tok = (pend_one || !ev_half) ? TOK_ONE : TOK_HALF;
        pop      = (level != 3'd0) && !bus.hold;
        accept   = push_vld && bus.accept_en && (level != FULL || pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_one <= 1'b0;
            fifo     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            half_q   <= 1'b0;
            one_q    <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            pend_one <= !pend_one && ev_half && ev_one;
            if (accept) begin
                fifo[wr_ptr] <= push_tok;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            level    <= level + 3'(accept) - 3'(pop);
            half_q   <= pop && (fifo[rd_ptr] == TOK_HALF);
            one_q    <= pop && (fifo[rd_ptr] == TOK_ONE);
            reject_q <= push_vld && !accept;
        end
    end

    assign bus.half       = half_q;
    assign bus.one        = one_q;
    assign bus.reject     = reject_q;
    assign bus.fifo_level = level;

`ifdef COIN_TOTAL_EN
    logic [7:0] credit;
    logic [8:0] credit_sum;

    assign credit_sum = {1'b0, credit} + ((push_tok == TOK_ONE) ? 9'd2 : 9'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      credit <= '0;
        else if (accept) credit <= credit_sum[8] ? 8'd255 : credit_sum[7:0];
    end

    assign bus.credit_total = credit;
`endif
endmodule
